mem_port_arbiter: RTL and testbench

- Sequences the single shared L2/memory port between three miss-path requesters: I-cache line fill, D-cache load line fill, and D-cache store write-through.
- Sits between the instruction/data caches and the L2 model.
- Grants one requester at a time, issues its transaction downstream, and holds exactly one outstanding transaction.
- Routes the read response or write-done back to the owning requester.

---
 rtl/mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one L2/memory port between I-fill,
// D-fill and D-store write-through; one transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int LINE_W       = 256,
  parameter int DATA_W       = 64,
  parameter int BE_W         = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ack,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_resp_data,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ack,
  output logic              ld_resp_valid,
  output logic [LINE_W-1:0] ld_resp_data,
  input  logic              st_req_valid,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  input  logic [BE_W-1:0]   st_req_be,
  output logic              st_req_ack,
  output logic              st_complete,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [BE_W-1:0]   mem_req_be,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  input  logic              mem_wr_done,
  output logic              err_o
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR
  } state_e;

  typedef enum logic [1:0] {
    OWN_IC,
    OWN_LD,
    OWN_ST
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              req_vld_q, req_vld_d;
  logic              ic_ack_q, ic_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic              st_ack_q, st_ack_d;
  logic              ic_rv_q, ic_rv_d;
  logic              ld_rv_q, ld_rv_d;
  logic              st_cmp_q, st_cmp_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] ld_rdata_q, ld_rdata_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              err_q, err_d;

  logic ic_win;
  logic ld_win;
  logic st_win;
  logic any_v;

  // Winner select: st > ld > ic unless the I-side has starved.
  always_comb begin
    ic_win = ic_req_valid &&
             ((starve_q == SC_MAX) ||
              (!st_req_valid && !ld_req_valid));
    st_win = st_req_valid && !ic_win;
    ld_win = ld_req_valid && !st_req_valid && !ic_win;
    any_v  = ic_req_valid || ld_req_valid || st_req_valid;
  end

  // Next-state, transaction latch, response routing and errors.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    req_vld_d  = req_vld_q;
    ic_ack_d   = 1'b0;
    ld_ack_d   = 1'b0;
    st_ack_d   = 1'b0;
    ic_rv_d    = 1'b0;
    ld_rv_d    = 1'b0;
    st_cmp_d   = 1'b0;
    ic_rdata_d = ic_rdata_q;
    ld_rdata_d = ld_rdata_q;
    starve_d   = starve_q;
    err_d      = err_q;

    if (mem_resp_valid && (state_q != WAIT_RD)) begin
      err_d = 1'b1;
    end
    if (mem_wr_done && (state_q != WAIT_WR)) begin
      err_d = 1'b1;
    end

    if (!ic_req_valid) begin
      starve_d = '0;
    end else if (state_q == IDLE) begin
      if (ic_win) begin
        starve_d = '0;
      end else if (starve_q != SC_MAX) begin
        starve_d = starve_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          state_d   = ISSUE;
          req_vld_d = 1'b1;
          unique case (1'b1)
            st_win: begin
              owner_d  = OWN_ST;
              we_d     = 1'b1;
              addr_d   = st_req_addr;
              wdata_d  = st_req_data;
              be_d     = st_req_be;
              st_ack_d = 1'b1;
            end
            ld_win: begin
              owner_d  = OWN_LD;
              we_d     = 1'b0;
              addr_d   = ld_req_addr;
              wdata_d  = '0;
              be_d     = '0;
              ld_ack_d = 1'b1;
            end
            ic_win: begin
              owner_d  = OWN_IC;
              we_d     = 1'b0;
              addr_d   = ic_req_addr;
              wdata_d  = '0;
              be_d     = '0;
              ic_ack_d = 1'b1;
            end
          endcase
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          req_vld_d = 1'b0;
          state_d   = we_q ? WAIT_WR : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_IC) begin
            ic_rv_d    = 1'b1;
            ic_rdata_d = mem_resp_data;
          end else begin
            ld_rv_d    = 1'b1;
            ld_rdata_d = mem_resp_data;
          end
        end
      end
      WAIT_WR: begin
        if (mem_wr_done) begin
          state_d  = IDLE;
          st_cmp_d = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      req_vld_q  <= 1'b0;
      ic_ack_q   <= 1'b0;
      ld_ack_q   <= 1'b0;
      st_ack_q   <= 1'b0;
      ic_rv_q    <= 1'b0;
      ld_rv_q    <= 1'b0;
      st_cmp_q   <= 1'b0;
      ic_rdata_q <= '0;
      ld_rdata_q <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      req_vld_q  <= req_vld_d;
      ic_ack_q   <= ic_ack_d;
      ld_ack_q   <= ld_ack_d;
      st_ack_q   <= st_ack_d;
      ic_rv_q    <= ic_rv_d;
      ld_rv_q    <= ld_rv_d;
      st_cmp_q   <= st_cmp_d;
      ic_rdata_q <= ic_rdata_d;
      ld_rdata_q <= ld_rdata_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  assign ic_req_ack    = ic_ack_q;
  assign ld_req_ack    = ld_ack_q;
  assign st_req_ack    = st_ack_q;
  assign ic_resp_valid = ic_rv_q;
  assign ld_resp_valid = ld_rv_q;
  assign st_complete   = st_cmp_q;
  assign ic_resp_data  = ic_rdata_q;
  assign ld_resp_data  = ld_rdata_q;
  assign mem_req_valid = req_vld_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner cases and a
// randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int LINE_W = 256;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int LIM    = 8;

  localparam logic [ADDR_W-1:0] IC_A = 64'h8000_0040;
  localparam logic [ADDR_W-1:0] LD_A = 64'h0000_1000;
  localparam logic [ADDR_W-1:0] ST_A = 64'h0000_2008;
  localparam logic [DATA_W-1:0] ST_D = 64'h1122334455667788;
  localparam logic [BE_W-1:0]   ST_B = 8'h0F;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ic_req_valid, ic_req_ack, ic_resp_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic [LINE_W-1:0] ic_resp_data;
  logic              ld_req_valid, ld_req_ack, ld_resp_valid;
  logic [ADDR_W-1:0] ld_req_addr;
  logic [LINE_W-1:0] ld_resp_data;
  logic              st_req_valid, st_req_ack, st_complete;
  logic [ADDR_W-1:0] st_req_addr;
  logic [DATA_W-1:0] st_req_data;
  logic [BE_W-1:0]   st_req_be;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [BE_W-1:0]   mem_req_be;
  logic              mem_resp_valid, mem_wr_done, err_o;
  logic [LINE_W-1:0] mem_resp_data;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DATA_W(DATA_W),
    .BE_W(BE_W), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_req_ack(ic_req_ack), .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
    .ld_req_ack(ld_req_ack), .ld_resp_valid(ld_resp_valid),
    .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_be(st_req_be),
    .st_req_ack(st_req_ack), .st_complete(st_complete),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_wr_done(mem_wr_done), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // requester bits are ordered {st, ld, ic}
  typedef struct {
    logic [2:0]        v;
    logic [2:0]        ack;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } vec_t;

  vec_t tbl[8];

  int pct[3];
  int rdy_pct;
  int max_dly;
  int losses;
  int mph;
  int dly;
  int exp_own;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  logic [BE_W-1:0]   exp_be;
  logic [LINE_W-1:0] exp_rdata;
  int ack_log[$];
  int cmp_log[$];

  task automatic chk(input string nm,
                     input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] acks();
    return {st_req_ack, ld_req_ack, ic_req_ack};
  endfunction

  function automatic logic [2:0] resps();
    return {st_complete, ld_resp_valid, ic_resp_valid};
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    ld_req_valid = 0; ld_req_addr = '0;
    st_req_valid = 0; st_req_addr = '0;
    st_req_data = '0; st_req_be = '0;
    mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_data = '0; mem_wr_done = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    tick();
    tick();
    reset = 1;
    losses = 0;
    mph = 0;
    dly = 0;
  endtask

  task automatic set_reqs(input logic [2:0] v);
    st_req_valid = v[2]; st_req_addr = ST_A;
    st_req_data = ST_D; st_req_be = ST_B;
    ld_req_valid = v[1]; ld_req_addr = LD_A;
    ic_req_valid = v[0]; ic_req_addr = IC_A;
  endtask

  // One cycle of requesters + memory, checked against a model that
  // tracks only "who owns the port" and "how often ic has lost".
  task automatic auto_run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic [2:0] v, eack, eresp;
      int win;
      bit dec, hs, rsp;
      if (ic_req_valid && ic_req_ack) ic_req_valid = 0;
      else if (!ic_req_valid && $urandom_range(99) < pct[0]) begin
        ic_req_valid = 1;
        ic_req_addr = {$urandom, $urandom} & ~64'h3F;
      end
      if (ld_req_valid && ld_req_ack) ld_req_valid = 0;
      else if (!ld_req_valid && $urandom_range(99) < pct[1]) begin
        ld_req_valid = 1;
        ld_req_addr = {$urandom, $urandom} & ~64'h3F;
      end
      if (st_req_valid && st_req_ack) st_req_valid = 0;
      else if (!st_req_valid && $urandom_range(99) < pct[2]) begin
        st_req_valid = 1;
        st_req_addr = {$urandom, $urandom};
        st_req_data = {$urandom, $urandom};
        st_req_be = 8'($urandom_range(255));
      end
      mem_req_ready = 0; mem_resp_valid = 0; mem_wr_done = 0;
      dec = 0; hs = 0; rsp = 0; eack = 0; eresp = 0; win = 0;
      if (mph == 1) begin
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        hs = mem_req_ready;
      end else if (mph == 2) begin
        if (dly == 0) begin
          rsp = 1;
          eresp[exp_own] = 1'b1;
          if (exp_we) mem_wr_done = 1;
          else begin
            mem_resp_valid = 1;
            mem_resp_data = rnd_line();
            exp_rdata = mem_resp_data;
          end
        end else dly--;
      end else begin
        v = {st_req_valid, ld_req_valid, ic_req_valid};
        if (v != 0) begin
          dec = 1;
          if (v[0] && losses == LIM) win = 0;
          else if (v[2]) win = 2;
          else if (v[1]) win = 1;
          else win = 0;
          eack[win] = 1'b1;
          exp_own = win;
          exp_we = (win == 2);
          exp_addr = (win == 2) ? st_req_addr :
                     (win == 1) ? ld_req_addr : ic_req_addr;
          exp_wdata = st_req_data;
          exp_be = st_req_be;
          if (v[0]) losses = (win == 0) ? 0 :
                             (losses < LIM) ? losses + 1 : LIM;
        end
      end
      if (!ic_req_valid) losses = 0;
      tick();
      if (st_req_ack) ack_log.push_back(2);
      if (ld_req_ack) ack_log.push_back(1);
      if (ic_req_ack) ack_log.push_back(0);
      if (st_complete) cmp_log.push_back(2);
      if (ld_resp_valid) cmp_log.push_back(1);
      if (ic_resp_valid) cmp_log.push_back(0);
      chk("auto_ack", acks(), eack);
      chk("auto_resp", resps(), eresp);
      if (dec) mph = 1;
      else if (hs) begin
        mph = 2;
        dly = $urandom_range(max_dly);
      end else if (rsp) mph = 0;
      chk("auto_mvalid", mem_req_valid, mph == 1);
      if (mph == 1) begin
        chk("auto_addr", mem_req_addr, exp_addr);
        chk("auto_we", mem_req_we, exp_we);
        if (exp_we) begin
          chk("auto_wdata", mem_req_wdata, exp_wdata);
          chk("auto_be", mem_req_be, exp_be);
        end
      end
      if (rsp && !exp_we) begin
        chk("auto_rdata",
            (exp_own == 0) ? ic_resp_data : ld_resp_data, exp_rdata);
      end
      chk("auto_err", err_o, 1'b0);
    end
  endtask

  initial begin
    logic [LINE_W-1:0] pat;
    logic [LINE_W-1:0] a5;
    bit ic_seen;
    tbl[0] = '{3'b001, 3'b001, 1'b0, IC_A};
    tbl[1] = '{3'b010, 3'b010, 1'b0, LD_A};
    tbl[2] = '{3'b100, 3'b100, 1'b1, ST_A};
    tbl[3] = '{3'b011, 3'b010, 1'b0, LD_A};
    tbl[4] = '{3'b000, 3'b000, 1'b0, '0};
    tbl[5] = '{3'b101, 3'b100, 1'b1, ST_A};
    tbl[6] = '{3'b110, 3'b100, 1'b1, ST_A};
    tbl[7] = '{3'b111, 3'b100, 1'b1, ST_A};
    a5 = {(LINE_W / 8){8'hA5}};
    pct = '{0, 0, 0};
    rdy_pct = 100;
    max_dly = 0;

    do_reset();
    chk("rst_mvalid", mem_req_valid, 1'b0);
    chk("rst_acks", acks(), 3'b000);
    chk("rst_resps", resps(), 3'b000);
    chk("rst_err", err_o, 1'b0);
    chk("rst_addr", mem_req_addr, '0);

    // minimum-latency I-cache fill, then immediate regrant
    ic_req_valid = 1; ic_req_addr = IC_A;
    tick();
    chk("t2_ack", acks(), 3'b001);
    chk("t2_mvalid", mem_req_valid, 1'b1);
    chk("t2_addr", mem_req_addr, IC_A);
    chk("t2_we", mem_req_we, 1'b0);
    ic_req_valid = 0; mem_req_ready = 1;
    tick();
    chk("t2_mvalid_drop", mem_req_valid, 1'b0);
    chk("t2_ack_pulse", acks(), 3'b000);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = a5;
    tick();
    chk("t2_resp", resps(), 3'b001);
    chk("t2_rdata", ic_resp_data, a5);
    mem_resp_valid = 0; mem_resp_data = '0;
    ld_req_valid = 1; ld_req_addr = 64'h40;
    tick();
    chk("t2_regrant", acks(), 3'b010);
    chk("t2_resp_pulse", resps(), 3'b000);
    chk("t2_rdata_hold", ic_resp_data, a5);
    ld_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = ~a5;
    tick();
    mem_resp_valid = 0;
    chk("t2_ld_rdata", ld_resp_data, ~a5);
    chk("t2_ic_rdata_kept", ic_resp_data, a5);

    // priority table
    for (int i = 0; i < 8; i++) begin
      set_reqs(tbl[i].v);
      tick();
      chk($sformatf("tbl%0d_ack", i), acks(), tbl[i].ack);
      chk($sformatf("tbl%0d_mvalid", i), mem_req_valid, |tbl[i].ack);
      set_reqs(3'b000);
      if (|tbl[i].ack) begin
        chk($sformatf("tbl%0d_we", i), mem_req_we, tbl[i].we);
        chk($sformatf("tbl%0d_addr", i), mem_req_addr, tbl[i].addr);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        pat = {8{32'hC0DE_0000 | 32'(i)}};
        if (tbl[i].we) mem_wr_done = 1;
        else begin
          mem_resp_valid = 1;
          mem_resp_data = pat;
        end
        tick();
        mem_wr_done = 0; mem_resp_valid = 0;
        chk($sformatf("tbl%0d_resp", i), resps(), tbl[i].ack);
        if (tbl[i].ack[0]) chk($sformatf("tbl%0d_icd", i), ic_resp_data, pat);
        if (tbl[i].ack[1]) chk($sformatf("tbl%0d_ldd", i), ld_resp_data, pat);
      end
    end
    chk("tbl_err", err_o, 1'b0);

    // store stalled by mem_req_ready
    st_req_valid = 1; st_req_addr = ST_A;
    st_req_data = ST_D; st_req_be = ST_B;
    tick();
    chk("t5_ack", acks(), 3'b100);
    st_req_valid = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t5_mvalid%0d", k), mem_req_valid, 1'b1);
      chk($sformatf("t5_addr%0d", k), mem_req_addr, ST_A);
      chk($sformatf("t5_wdata%0d", k), mem_req_wdata, ST_D);
      chk($sformatf("t5_be%0d", k), mem_req_be, ST_B);
      chk($sformatf("t5_we%0d", k), mem_req_we, 1'b1);
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    chk("t5_mvalid_drop", mem_req_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("t5_wait%0d", k), st_complete, 1'b0);
    end
    mem_wr_done = 1;
    tick();
    mem_wr_done = 0;
    chk("t5_complete", st_complete, 1'b1);
    tick();
    chk("t5_complete_pulse", st_complete, 1'b0);
    chk("t5_err", err_o, 1'b0);

    // write-done while waiting for read data
    ld_req_valid = 1; ld_req_addr = 64'h3000;
    tick();
    ld_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_wr_done = 1;
    tick();
    mem_wr_done = 0;
    chk("t6_err", err_o, 1'b1);
    chk("t6_no_resp", resps(), 3'b000);
    pat = rnd_line();
    mem_resp_valid = 1; mem_resp_data = pat;
    tick();
    mem_resp_valid = 0;
    chk("t6_resp", resps(), 3'b010);
    chk("t6_rdata", ld_resp_data, pat);
    chk("t6_err_sticky", err_o, 1'b1);

    // reset in the middle of a read
    do_reset();
    chk("t1_err_cleared", err_o, 1'b0);
    ic_req_valid = 1; ic_req_addr = 64'h1000;
    tick();
    ic_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    reset = 0;
    tick();
    reset = 1;
    chk("t1_mvalid", mem_req_valid, 1'b0);
    chk("t1_addr", mem_req_addr, '0);
    chk("t1_acks", acks(), 3'b000);
    chk("t1_resps", resps(), 3'b000);
    chk("t1_err0", err_o, 1'b0);
    mem_resp_valid = 1; mem_resp_data = a5;
    tick();
    mem_resp_valid = 0;
    chk("t1_late_err", err_o, 1'b1);
    chk("t1_no_icresp", ic_resp_valid, 1'b0);

    // all three at once
    do_reset();
    set_reqs(3'b111);
    pct = '{0, 0, 0}; rdy_pct = 100; max_dly = 0;
    ack_log.delete(); cmp_log.delete();
    auto_run(20);
    chk("t3_nacks", ack_log.size(), 3);
    chk("t3_ncmp", cmp_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_ack%0d", k),
          (ack_log.size() > k) ? ack_log[k] : -1, 2 - k);
      chk($sformatf("t3_cmp%0d", k),
          (cmp_log.size() > k) ? cmp_log[k] : -1, 2 - k);
    end

    // starvation: ld and st keep re-requesting
    do_reset();
    ic_req_valid = 1; ic_req_addr = 64'h40;
    pct = '{0, 100, 100}; rdy_pct = 100; max_dly = 0;
    ack_log.delete(); cmp_log.delete();
    ic_seen = 0;
    for (int k = 0; k < 80 && !ic_seen; k++) begin
      auto_run(1);
      if (ic_req_ack) ic_seen = 1;
    end
    chk("t4_ic_granted", ic_seen, 1'b1);
    chk("t4_losses", ack_log.size() - 1, LIM);
    chk("t4_starve_clr", dut.starve_q, '0);
    pct = '{0, 0, 0};
    auto_run(30);

    // randomized traffic
    do_reset();
    pct = '{40, 40, 40}; rdy_pct = 60; max_dly = 3;
    ack_log.delete(); cmp_log.delete();
    auto_run(1500);
    pct = '{0, 0, 0};
    auto_run(80);
    chk("rnd_all_done", ack_log.size(), cmp_log.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
